// File: rtl/red_pitaya_trg_ext_if.sv
// rtl/red_pitaya_trg_ext_if.sv - trigger-conditioner configuration/control/status bundle
//
// Purpose : carries the external trigger pin, configuration, control pulses and status outputs
//           of red_pitaya_trg_ext between the register side (master) and the conditioner (slave).
// Signals : trg_ext_i          raw asynchronous trigger pin
//           cfg_edg_i          edge select, 0 = rising, 1 = falling
//           cfg_deb_i[DWC]     debounce length in cycles
//           cfg_hld_i[HWC]     holdoff length in cycles
//           ctl_arm_i          arm pulse
//           ctl_rst_i          disarm pulse, clears FSM and counter
//           trg_o              one-cycle conditioned trigger
//           sts_arm_o          FSM in ARMED
//           sts_hld_o          FSM in HOLD
//           cnt_trg_o[CWC]     saturating accepted-trigger count
//           ts_trg_o[64]       last trigger timestamp (TRG_EXT_TIMESTAMP_EN only)
// Macro   : TRG_EXT_TIMESTAMP_EN

interface red_pitaya_trg_ext_if #(
  parameter int DWC = 20,
  parameter int HWC = 32,
  parameter int CWC = 32
);
  logic           trg_ext_i;
  logic           cfg_edg_i;
  logic [DWC-1:0] cfg_deb_i;
  logic [HWC-1:0] cfg_hld_i;
  logic           ctl_arm_i;
  logic           ctl_rst_i;
  logic           trg_o;
  logic           sts_arm_o;
  logic           sts_hld_o;
  logic [CWC-1:0] cnt_trg_o;
`ifdef TRG_EXT_TIMESTAMP_EN
  logic [63:0]    ts_trg_o;
`endif

`ifdef TRG_EXT_TIMESTAMP_EN
  modport master (
    output trg_ext_i, cfg_edg_i, cfg_deb_i, cfg_hld_i, ctl_arm_i, ctl_rst_i,
    input  trg_o, sts_arm_o, sts_hld_o, cnt_trg_o, ts_trg_o
  );
  modport slave (
    input  trg_ext_i, cfg_edg_i, cfg_deb_i, cfg_hld_i, ctl_arm_i, ctl_rst_i,
    output trg_o, sts_arm_o, sts_hld_o, cnt_trg_o, ts_trg_o
  );
`else
  modport master (
    output trg_ext_i, cfg_edg_i, cfg_deb_i, cfg_hld_i, ctl_arm_i, ctl_rst_i,
    input  trg_o, sts_arm_o, sts_hld_o, cnt_trg_o
  );
  modport slave (
    input  trg_ext_i, cfg_edg_i, cfg_deb_i, cfg_hld_i, ctl_arm_i, ctl_rst_i,
    output trg_o, sts_arm_o, sts_hld_o, cnt_trg_o
  );
`endif
endinterface

// File: rtl/red_pitaya_trg_ext.sv
// rtl/red_pitaya_trg_ext.sv - external trigger synchroniser, debouncer, edge detector and arm/holdoff FSM
//
// Purpose : conditions the expansion-connector trigger pin into one-cycle trigger pulses for the
//           scope and ASG trigger muxes, with debounce, edge select, arm control and holdoff.
// Ports   : clk_i  125 MHz ADC clock (single domain)
//           rst_i  synchronous active-high reset
//           bus    red_pitaya_trg_ext_if.slave (pin, cfg_*, ctl_*, trg_o, sts_*, cnt_trg_o, ts_trg_o)
// Macro   : TRG_EXT_TIMESTAMP_EN adds a 64-bit free-running timestamp latched on every trigger.

module red_pitaya_trg_ext #(
  parameter int DWC = 20,
  parameter int HWC = 32,
  parameter int CWC = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  red_pitaya_trg_ext_if.slave    bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic           r_sy1;
  logic           r_sy2;
  logic           r_lvl;
  logic           r_lvl_d;
  logic [DWC-1:0] r_deb_cnt;
  logic [1:0]     r_state;
  logic [HWC-1:0] r_hld_cnt;
  logic [CWC-1:0] r_cnt_trg;
  logic           r_trg;
  logic           w_rise;
  logic           w_fall;
  logic           w_edge;

`ifdef TRG_EXT_TIMESTAMP_EN
  logic [63:0]    r_ts_cnt;
  logic [63:0]    r_ts_trg;
`endif

  // Synchroniser and debouncer keep running regardless of FSM state, so arming
  // always sees a settled level and needs a fresh edge to fire.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sy1     <= 1'b0;
      r_sy2     <= 1'b0;
      r_lvl     <= 1'b0;
      r_lvl_d   <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_sy1   <= bus.trg_ext_i;
      r_sy2   <= r_sy1;
      r_lvl_d <= r_lvl;
      if (r_sy2 != r_lvl) begin
        // The new level must persist for cfg_deb_i+1 samples before it is accepted.
        if (r_deb_cnt == bus.cfg_deb_i) begin
          r_lvl     <= r_sy2;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  // Both detectors look only at the debounced level, so flipping cfg_edg_i
  // while the level is steady selects between two zeros.
  assign w_rise = r_lvl & ~r_lvl_d;
  assign w_fall = ~r_lvl & r_lvl_d;
  assign w_edge = bus.cfg_edg_i ? w_fall : w_rise;

`ifdef TRG_EXT_TIMESTAMP_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ts_cnt <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 64'd1;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_hld_cnt <= '0;
      r_cnt_trg <= '0;
      r_trg     <= 1'b0;
`ifdef TRG_EXT_TIMESTAMP_EN
      r_ts_trg  <= '0;
`endif
    end else begin
      r_trg <= 1'b0;
      // Disarm wins over arm and over an edge arriving in the same cycle.
      if (bus.ctl_rst_i) begin
        r_state   <= S_IDLE;
        r_hld_cnt <= '0;
        r_cnt_trg <= '0;
`ifdef TRG_EXT_TIMESTAMP_EN
        r_ts_trg  <= '0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.ctl_arm_i) begin
              r_state <= S_ARMED;
            end
          end
          S_ARMED: begin
            if (w_edge) begin
              r_trg <= 1'b1;
              if (r_cnt_trg != '1) begin
                r_cnt_trg <= r_cnt_trg + 1'b1;
              end
`ifdef TRG_EXT_TIMESTAMP_EN
              r_ts_trg <= r_ts_cnt;
`endif
              if (bus.cfg_hld_i != '0) begin
                r_hld_cnt <= bus.cfg_hld_i;
                r_state   <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            // The <= guard also recovers from a zero count, which cannot be loaded.
            if (r_hld_cnt <= HWC'(1)) begin
              r_hld_cnt <= '0;
              r_state   <= S_ARMED;
            end else begin
              r_hld_cnt <= r_hld_cnt - 1'b1;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_hld_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign bus.trg_o     = r_trg;
  assign bus.sts_arm_o = (r_state == S_ARMED);
  assign bus.sts_hld_o = (r_state == S_HOLD);
  assign bus.cnt_trg_o = r_cnt_trg;
`ifdef TRG_EXT_TIMESTAMP_EN
  assign bus.ts_trg_o  = r_ts_trg;
`endif

endmodule

// File: tb/tb_red_pitaya_trg_ext.sv
// tb/tb_red_pitaya_trg_ext.sv - directed table-driven bench for red_pitaya_trg_ext

module tb_red_pitaya_trg_ext;

  localparam int DWC = 20;
  localparam int HWC = 32;
  localparam int CWC = 4;

  typedef struct {
    int deb;
    bit edg;
    int len;
    int exp_n;
    int exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  red_pitaya_trg_ext_if #(.DWC(DWC), .HWC(HWC), .CWC(CWC)) bus ();

  red_pitaya_trg_ext #(.DWC(DWC), .HWC(HWC), .CWC(CWC)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #4 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_ctl_rst();
    bus.ctl_rst_i = 1'b1;
    tick();
    bus.ctl_rst_i = 1'b0;
  endtask

  task automatic pulse_arm();
    bus.ctl_arm_i = 1'b1;
    tick();
    bus.ctl_arm_i = 1'b0;
  endtask

  vec_t vecs[9];
  int   n;
  int   lat;
  int   kt;
  bit   hld_seen;
  longint tsv;

  initial begin
    vecs[0] = '{deb: 0,  edg: 1'b0, len: 3,  exp_n: 1, exp_lat: 4};
    vecs[1] = '{deb: 0,  edg: 1'b0, len: 1,  exp_n: 1, exp_lat: 4};
    vecs[2] = '{deb: 10, edg: 1'b0, len: 5,  exp_n: 0, exp_lat: -1};
    vecs[3] = '{deb: 10, edg: 1'b0, len: 10, exp_n: 0, exp_lat: -1};
    vecs[4] = '{deb: 10, edg: 1'b0, len: 11, exp_n: 1, exp_lat: 14};
    vecs[5] = '{deb: 10, edg: 1'b0, len: 20, exp_n: 1, exp_lat: 14};
    vecs[6] = '{deb: 0,  edg: 1'b1, len: 6,  exp_n: 1, exp_lat: 10};
    vecs[7] = '{deb: 3,  edg: 1'b1, len: 8,  exp_n: 1, exp_lat: 15};
    vecs[8] = '{deb: 5,  edg: 1'b1, len: 5,  exp_n: 0, exp_lat: -1};

    bus.trg_ext_i = 1'b0;
    bus.cfg_edg_i = 1'b0;
    bus.cfg_deb_i = '0;
    bus.cfg_hld_i = '0;
    bus.ctl_arm_i = 1'b0;
    bus.ctl_rst_i = 1'b0;

    // Reset state
    ticks(3);
    check("rst_trg", bus.trg_o, 0);
    check("rst_arm", bus.sts_arm_o, 0);
    check("rst_hld", bus.sts_hld_o, 0);
    check("rst_cnt", bus.cnt_trg_o, 0);
`ifdef TRG_EXT_TIMESTAMP_EN
    check("rst_ts", bus.ts_trg_o, 0);
`endif
    rst = 1'b0;

`ifdef TRG_EXT_TIMESTAMP_EN
    // Timestamp: trigger lands on the 1000th edge after reset release; ts_cnt reads 999 then.
    pulse_arm();
    kt = -1;
    tsv = -1;
    for (int k = 2; k <= 1010; k++) begin
      tick();
      if (bus.trg_o && kt < 0) begin
        kt = k;
        tsv = longint'(bus.ts_trg_o);
      end
      if (k == 996) bus.trg_ext_i = 1'b1;
    end
    check("ts_trg_edge", kt, 1000);
    check("ts_trg_val", tsv, 999);
    bus.trg_ext_i = 1'b0;
    ticks(10);
    pulse_ctl_rst();
    check("ts_ctl_rst_clr", bus.ts_trg_o, 0);
`endif

    // Single-pulse vectors: debounce, glitch rejection, edge select, latency
    foreach (vecs[v]) begin
      pulse_ctl_rst();
      bus.cfg_deb_i = DWC'(vecs[v].deb);
      bus.cfg_edg_i = vecs[v].edg;
      bus.cfg_hld_i = '0;
      ticks(2);
      pulse_arm();
      bus.trg_ext_i = 1'b1;
      n = 0;
      lat = -1;
      for (int i = 1; i <= 80; i++) begin
        tick();
        if (bus.trg_o) begin
          n++;
          if (lat < 0) lat = i;
        end
        if (i == vecs[v].len) bus.trg_ext_i = 1'b0;
      end
      check($sformatf("vec%0d_npulse", v), n, vecs[v].exp_n);
      check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("vec%0d_cnt", v), bus.cnt_trg_o, vecs[v].exp_n);
      check($sformatf("vec%0d_armed", v), bus.sts_arm_o, 1);
    end

    // Holdoff 100, pulses every 60 cycles x4: only pulses 1 and 3 fire
    pulse_ctl_rst();
    bus.cfg_deb_i = '0;
    bus.cfg_edg_i = 1'b0;
    bus.cfg_hld_i = HWC'(100);
    pulse_arm();
    n = 0;
    hld_seen = 1'b0;
    for (int i = 0; i < 260; i++) begin
      if (i < 240 && i % 60 == 0) bus.trg_ext_i = 1'b1;
      if (i % 60 == 5) bus.trg_ext_i = 1'b0;
      tick();
      if (bus.trg_o) n++;
      if (bus.sts_hld_o) hld_seen = 1'b1;
    end
    check("hold_npulse", n, 2);
    check("hold_cnt", bus.cnt_trg_o, 2);
    check("hold_seen", hld_seen, 1);
    check("hold_rearmed", bus.sts_arm_o, 1);

    // Falling edge, long pulses
    pulse_ctl_rst();
    bus.cfg_deb_i = DWC'(10);
    bus.cfg_edg_i = 1'b1;
    bus.cfg_hld_i = '0;
    pulse_arm();
    n = 0;
    lat = -1;
    for (int i = 0; i < 9000; i++) begin
      if (i % 3000 == 0) bus.trg_ext_i = 1'b1;
      if (i % 3000 == 1200) bus.trg_ext_i = 1'b0;
      tick();
      if (bus.trg_o) begin
        n++;
        if (lat < 0) lat = i + 1;
      end
    end
    check("fall_npulse", n, 3);
    check("fall_cnt", bus.cnt_trg_o, 3);
    check("fall_first_at", lat, 1200 + 4 + 10);

    // ctl_rst_i collides with an accepted edge
    pulse_ctl_rst();
    bus.cfg_deb_i = '0;
    bus.cfg_edg_i = 1'b0;
    ticks(20);
    pulse_arm();
    bus.trg_ext_i = 1'b1;
    ticks(3);
    bus.ctl_rst_i = 1'b1;
    n = 0;
    tick();
    if (bus.trg_o) n++;
    bus.ctl_rst_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.trg_o) n++;
    end
    check("coll_npulse", n, 0);
    check("coll_cnt", bus.cnt_trg_o, 0);
    check("coll_idle", bus.sts_arm_o, 0);
    bus.trg_ext_i = 1'b0;
    ticks(10);
    pulse_arm();
    bus.trg_ext_i = 1'b1;
    ticks(10);
    check("coll_rearm_cnt", bus.cnt_trg_o, 1);

    // Arming while the level is already high needs a fresh edge
    pulse_ctl_rst();
    ticks(10);
    pulse_arm();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.trg_o) n++;
    end
    check("armhigh_npulse", n, 0);
    check("armhigh_armed", bus.sts_arm_o, 1);
    bus.trg_ext_i = 1'b0;
    ticks(5);
    bus.trg_ext_i = 1'b1;
    ticks(6);
    check("armhigh_then_edge", bus.cnt_trg_o, 1);
    bus.trg_ext_i = 1'b0;
    ticks(6);

    // Saturating count (CWC=4 -> 15)
    pulse_ctl_rst();
    pulse_arm();
    n = 0;
    for (int p = 0; p < 17; p++) begin
      bus.trg_ext_i = 1'b1;
      tick();
      if (bus.trg_o) n++;
      tick();
      if (bus.trg_o) n++;
      bus.trg_ext_i = 1'b0;
      tick();
      if (bus.trg_o) n++;
      tick();
      if (bus.trg_o) n++;
    end
    ticks(6);
    check("sat_npulse", n, 17);
    check("sat_cnt", bus.cnt_trg_o, 15);

    // rst_i in the middle of HOLD
    pulse_ctl_rst();
    bus.cfg_hld_i = HWC'(1000);
    pulse_arm();
    bus.trg_ext_i = 1'b1;
    ticks(10);
    check("hold_mid_sts", bus.sts_hld_o, 1);
    check("hold_mid_cnt", bus.cnt_trg_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rsthold_trg", bus.trg_o, 0);
    check("rsthold_arm", bus.sts_arm_o, 0);
    check("rsthold_hld", bus.sts_hld_o, 0);
    check("rsthold_cnt", bus.cnt_trg_o, 0);
`ifdef TRG_EXT_TIMESTAMP_EN
    check("rsthold_ts", bus.ts_trg_o, 0);
`endif
    bus.trg_ext_i = 1'b0;
    ticks(5);
    bus.trg_ext_i = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.trg_o) n++;
    end
    check("idle_ignores_edge", n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
